// File: rtl/mem_responder_if.sv
// Request/acknowledge bus between the core's fetch/data requesters and mem_responder.
// The master modport is the core side; the slave modport is the responder side.
interface mem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_ack;
    logic [DATA_W-1:0] f_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              busy;

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata,
        input  f_ack, f_rdata, d_ack, d_rdata, busy
    );

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata,
        output f_ack, f_rdata, d_ack, d_rdata, busy
    );
endinterface

// File: rtl/mem_responder.sv
// Unified 2**ADDR_W x DATA_W program/data memory serving a fetch port and a load/store
// port over req/ack, with round-robin arbitration and optional wait states.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input logic            clk,
    input logic            reset,
    mem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic {FETCH, DATA} port_t;

    localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next;
    port_t             last_grant, port_q, sel_port, acc_port;
    logic [ADDR_W-1:0] addr_q, acc_addr;
    logic              we_q, acc_we;
    logic [DATA_W-1:0] wdata_q, acc_wdata;
    logic [DATA_W-1:0] f_rdata, d_rdata;
    logic              take, enter_resp, mem_we;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        take       = 1'b0;
        // Contention goes to the port that was not served last.
        if (bus.f_req && bus.d_req)
            sel_port = (last_grant == FETCH) ? DATA : FETCH;
        else if (bus.d_req)
            sel_port = DATA;
        else
            sel_port = FETCH;

        case (state)
            IDLE: begin
                if (bus.f_req || bus.d_req) begin
                    take = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_next = RESP;
                else             cnt_next   = cnt - 4'd1;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With zero wait states the access happens on the grant edge, before the latches load.
    assign acc_port   = take ? sel_port : port_q;
    assign acc_addr   = take ? ((sel_port == DATA) ? bus.d_addr : bus.f_addr) : addr_q;
    assign acc_we     = take ? ((sel_port == DATA) && bus.d_we) : we_q;
    assign acc_wdata  = take ? bus.d_wdata : wdata_q;
    assign enter_resp = (state_next == RESP);
    assign mem_we     = enter_resp && acc_we && !reset;

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= FETCH;
            port_q     <= FETCH;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            f_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (take) begin
                port_q  <= sel_port;
                addr_q  <= acc_addr;
                we_q    <= acc_we;
                wdata_q <= bus.d_wdata;
            end
            if (state == RESP) last_grant <= port_q;
            if (enter_resp && !acc_we) begin
                if (acc_port == FETCH) f_rdata <= mem[acc_addr];
                else                   d_rdata <= mem[acc_addr];
            end
        end
    end

    // NOTE: the memory array has no reset so it maps onto block RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[acc_addr] <= acc_wdata;
    end

    assign bus.f_ack   = (state == RESP) && (port_q == FETCH);
    assign bus.d_ack   = (state == RESP) && (port_q == DATA);
    assign bus.f_rdata = f_rdata;
    assign bus.d_rdata = d_rdata;
    assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: instance 0 has no wait states, instance 1 has three.
// Drivers push expected responses; a negedge monitor pops and compares on every ack.
module tb_mem_responder;
    typedef struct packed {
        logic       is_data;
        logic [7:0] f;
        logic [7:0] d;
    } exp_t;

    logic       clk;
    logic       rst     [2];
    logic       f_req   [2];
    logic       d_req   [2];
    logic       d_we    [2];
    logic [7:0] f_addr  [2];
    logic [7:0] d_addr  [2];
    logic [7:0] d_wdata [2];
    logic       f_ack   [2];
    logic       d_ack   [2];
    logic       busy    [2];
    logic [7:0] f_rdata [2];
    logic [7:0] d_rdata [2];

    int   assertions = 0;
    int   failures   = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t mon_e;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_responder_if bus ();
        mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(g == 0 ? 0 : 3)) dut (
            .clk  (clk),
            .reset(rst[g]),
            .bus  (bus)
        );
        assign bus.f_req   = f_req[g];
        assign bus.f_addr  = f_addr[g];
        assign bus.d_req   = d_req[g];
        assign bus.d_we    = d_we[g];
        assign bus.d_addr  = d_addr[g];
        assign bus.d_wdata = d_wdata[g];
        assign f_ack[g]    = bus.f_ack;
        assign d_ack[g]    = bus.d_ack;
        assign busy[g]     = bus.busy;
        assign f_rdata[g]  = bus.f_rdata;
        assign d_rdata[g]  = bus.d_rdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int u, input logic is_data, input logic [7:0] f, input logic [7:0] d);
        exp_t e;
        e.is_data = is_data;
        e.f       = f;
        e.d       = d;
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (f_ack[u] === 1'b1 || d_ack[u] === 1'b1) begin
                check($sformatf("ack_overlap%0d", u), {31'd0, f_ack[u] & d_ack[u]}, 32'd0);
                if ((u == 0 ? q0.size() : q1.size()) == 0) begin
                    assertions++;
                    failures++;
                    $display("FAIL unexpected_ack%0d: f_ack=%0b d_ack=%0b with nothing expected",
                             u, f_ack[u], d_ack[u]);
                end else begin
                    mon_e = (u == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("ack_port%0d", u), {31'd0, d_ack[u]}, {31'd0, mon_e.is_data});
                    check($sformatf("f_rdata%0d", u), {24'd0, f_rdata[u]}, {24'd0, mon_e.f});
                    check($sformatf("d_rdata%0d", u), {24'd0, d_rdata[u]}, {24'd0, mon_e.d});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int u, input bit fetch, output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if ((fetch ? f_ack[u] : d_ack[u]) === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            assertions++;
            failures++;
            $display("FAIL ack_timeout%0d: no ack within 40 cycles, expected one", u);
        end
    endtask

    task automatic check_reset(input int u);
        check($sformatf("rst_f_ack%0d", u),   {31'd0, f_ack[u]}, 32'd0);
        check($sformatf("rst_d_ack%0d", u),   {31'd0, d_ack[u]}, 32'd0);
        check($sformatf("rst_busy%0d", u),    {31'd0, busy[u]},  32'd0);
        check($sformatf("rst_f_rdata%0d", u), {24'd0, f_rdata[u]}, 32'd0);
        check($sformatf("rst_d_rdata%0d", u), {24'd0, d_rdata[u]}, 32'd0);
    endtask

    // Data transaction from IDLE; checks cycles from the sampling cycle (n=1) to ack.
    task automatic data_txn(input int u, input bit we, input logic [7:0] a, input logic [7:0] wd,
                            input int exp_n, input string name);
        int n;
        d_we[u]    = we;
        d_addr[u]  = a;
        d_wdata[u] = wd;
        d_req[u]   = 1'b1;
        wait_ack(u, 1'b0, n);
        check(name, n, exp_n);
        step();
        d_req[u] = 1'b0;
    endtask

    initial begin
        int n;
        int acks;
        int last_cyc;
        int bcnt;
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; f_req[u] = 1'b0; d_req[u] = 1'b0; d_we[u] = 1'b0;
            f_addr[u] = '0; d_addr[u] = '0; d_wdata[u] = '0;
        end
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        step();

        // Zero wait states: store then load at the top address.
        push(0, 1'b1, 8'h00, 8'h00);
        data_txn(0, 1'b1, 8'hFF, 8'h06, 2, "lat_store_ff");
        push(0, 1'b1, 8'h00, 8'h06);
        data_txn(0, 1'b0, 8'hFF, 8'h00, 2, "lat_load_ff");

        // Preload program bytes, then two fetches with f_req held.
        push(0, 1'b1, 8'h00, 8'h06);
        data_txn(0, 1'b1, 8'h00, 8'hEF, 2, "lat_store_00");
        push(0, 1'b1, 8'h00, 8'h06);
        data_txn(0, 1'b1, 8'h01, 8'hAF, 2, "lat_store_01");
        push(0, 1'b0, 8'hEF, 8'h06);
        push(0, 1'b0, 8'hAF, 8'h06);
        f_addr[0] = 8'h00;
        f_req[0]  = 1'b1;
        wait_ack(0, 1'b1, n);
        check("lat_fetch_00", n, 2);
        step();
        f_addr[0] = 8'h01;
        wait_ack(0, 1'b1, n);
        check("fetch_spacing", n, 2);
        step();
        f_req[0] = 1'b0;

        // Reset keeps memory; first contention afterwards goes to DATA, then alternates.
        #2;
        rst[0] = 1'b1;
        #1;
        check_reset(0);
        @(negedge clk);
        rst[0] = 1'b0;
        step();
        push(0, 1'b1, 8'h00, 8'h06);
        push(0, 1'b0, 8'hEF, 8'h06);
        push(0, 1'b1, 8'hEF, 8'h06);
        push(0, 1'b0, 8'hEF, 8'h06);
        f_addr[0] = 8'h00;
        d_we[0]   = 1'b0;
        d_addr[0] = 8'hFF;
        f_req[0]  = 1'b1;
        d_req[0]  = 1'b1;
        acks = 0;
        last_cyc = 0;
        for (int i = 1; i <= 40 && acks < 4; i++) begin
            @(negedge clk);
            if (f_ack[0] === 1'b1 || d_ack[0] === 1'b1) begin
                acks++;
                if (acks > 1) check("contend_spacing", i - last_cyc, 2);
                last_cyc = i;
            end
        end
        check("contend_acks", acks, 4);
        step();
        f_req[0] = 1'b0;
        d_req[0] = 1'b0;
        step();

        // Store then back-to-back load with d_req held through the store ack.
        push(0, 1'b1, 8'hEF, 8'h06);
        push(0, 1'b1, 8'hEF, 8'h77);
        d_we[0]    = 1'b1;
        d_addr[0]  = 8'hFF;
        d_wdata[0] = 8'h77;
        d_req[0]   = 1'b1;
        wait_ack(0, 1'b0, n);
        check("lat_store_77", n, 2);
        step();
        d_we[0] = 1'b0;
        wait_ack(0, 1'b0, n);
        check("b2b_spacing", n, 2);
        step();
        d_req[0] = 1'b0;

        // Three wait states: latency, busy window, inputs ignored while waiting.
        push(1, 1'b1, 8'h00, 8'h00);
        data_txn(1, 1'b1, 8'h10, 8'h5A, 5, "ws3_lat_store");
        push(1, 1'b1, 8'h00, 8'h5A);
        d_we[1]   = 1'b0;
        d_addr[1] = 8'h10;
        d_req[1]  = 1'b1;
        n = 0;
        bcnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy[1] === 1'b1) bcnt++;
            if (i == 2) begin
                d_addr[1]  = 8'h33;
                d_wdata[1] = 8'hCC;
            end
            if (d_ack[1] === 1'b1) begin
                n = i;
                break;
            end
        end
        check("ws3_lat_load", n, 5);
        check("ws3_busy_cycles", bcnt, 4);
        step();
        d_req[1] = 1'b0;

        // Reset in WAIT abandons a store.
        push(1, 1'b1, 8'h00, 8'h5A);
        data_txn(1, 1'b1, 8'h20, 8'h11, 5, "ws3_lat_store_20");
        step();
        d_we[1]    = 1'b1;
        d_addr[1]  = 8'h20;
        d_wdata[1] = 8'h3C;
        d_req[1]   = 1'b1;
        repeat (2) @(negedge clk);
        check("ws3_busy_in_wait", {31'd0, busy[1]}, 32'd1);
        rst[1] = 1'b1;
        #1;
        check_reset(1);
        d_req[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b0;
        step();
        push(1, 1'b1, 8'h00, 8'h11);
        data_txn(1, 1'b0, 8'h20, 8'h00, 5, "ws3_lat_load_20");

        repeat (3) step();
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
